// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative multiply/divide unit for the EX stage.
//
// Executes MULT/MULTU/DIV/DIVU in 32 iterations (shift-add multiply,
// restoring divide) and owns the architectural HI/LO registers. MTHI/MTLO
// write HI/LO in a single cycle.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   EX holds a valid HI/LO-class instruction
//   annul     in   EX instruction is flushed this cycle (masks start)
//   op        in   000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x no-op
//   src_a     in   rs operand (post-forwarding)
//   src_b     in   rt operand (post-forwarding)
//   stall     out  hold the front of the pipeline, bubble into EX/MEM
//   busy      out  iteration in progress (state BUSY)
//   hi, lo    out  HI/LO registers
//   dbgState  out  FSM state for observation (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: start is a qualified request sampled only in IDLE; when it is
// accepted as a mul/div, stall rises combinationally in the same cycle and
// stays high until the result has been written to HI/LO.
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        annul,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        stall,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT       state;
  stateT       stateNext;

  logic [4:0]  cnt;
  logic        isDiv;
  logic        negQ;
  logic        negR;
  logic        divZero;
  logic [31:0] rawA;     // dividend as presented, returned in HI on divide by zero
  logic [31:0] operand;  // multiplicand magnitude (mul) or divisor magnitude (div)
  logic [63:0] work;     // mul: product:multiplier, div: remainder:quotient

  logic        acc;
  logic        isMulDiv;
  logic        signedOp;
  logic        aNeg;
  logic        bNeg;
  logic [31:0] magA;
  logic [31:0] magB;

  logic [32:0] mulSum;
  logic [63:0] mulNext;
  logic [64:0] shifted;
  logic [32:0] divDiff;
  logic [63:0] divNext;
  logic [63:0] workNext;
  logic [63:0] mulRes;
  logic [31:0] resHi;
  logic [31:0] resLo;

  assign acc      = start & ~annul & (state == IDLE);
  assign isMulDiv = ~op[2];
  assign signedOp = ~op[0];
  assign aNeg     = signedOp & src_a[31];
  assign bNeg     = signedOp & src_b[31];
  assign magA     = aNeg ? -src_a : src_a;
  assign magB     = bNeg ? -src_b : src_b;

  assign stall    = ((state == IDLE) & acc & isMulDiv) | (state == BUSY);
  assign busy     = (state == BUSY);
  assign dbgState = state;

  // One iteration of either algorithm, plus the final result fixups.
  always_comb begin
    mulSum   = {1'b0, work[63:32]} + {1'b0, operand};
    mulNext  = work[0] ? {mulSum, work[31:1]} : {1'b0, work[63:1]};

    // Restoring divide: the shifted partial remainder can reach 33 bits,
    // so the trial subtraction is 33 bits wide and its MSB is the borrow.
    shifted  = {work, 1'b0};
    divDiff  = shifted[64:32] - {1'b0, operand};
    divNext  = divDiff[32] ? shifted[63:0]
                           : {divDiff[31:0], shifted[31:1], 1'b1};

    workNext = isDiv ? divNext : mulNext;

    mulRes   = negQ ? -workNext : workNext;
    resHi    = mulRes[63:32];
    resLo    = mulRes[31:0];
    if (isDiv) begin
      if (divZero) begin
        resHi = rawA;
        resLo = 32'hFFFF_FFFF;
      end else begin
        resLo = negQ ? -workNext[31:0]  : workNext[31:0];
        resHi = negR ? -workNext[63:32] : workNext[63:32];
      end
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (acc && isMulDiv) stateNext = BUSY;
      BUSY:    if (cnt == 5'd0) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 5'd0;
      isDiv   <= 1'b0;
      negQ    <= 1'b0;
      negR    <= 1'b0;
      divZero <= 1'b0;
      rawA    <= 32'd0;
      operand <= 32'd0;
      work    <= 64'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      state <= stateNext;
      case (state)
        IDLE: begin
          if (acc) begin
            if (isMulDiv) begin
              isDiv   <= op[1];
              negQ    <= aNeg ^ bNeg;
              negR    <= op[1] & aNeg;
              divZero <= op[1] & (src_b == 32'd0);
              rawA    <= src_a;
              operand <= op[1] ? magB : magA;
              work    <= op[1] ? {32'd0, magA} : {32'd0, magB};
              cnt     <= 5'd31;
            end else if (op == 3'b100) begin
              hi <= src_a;
            end else if (op == 3'b101) begin
              lo <= src_a;
            end
          end
        end
        BUSY: begin
          work <= workNext;
          if (cnt == 5'd0) begin
            hi <= resHi;
            lo <= resLo;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed scenarios plus a few random mul/div ops.
// Expected HI:LO values are pushed to exp_q when an operation is driven and
// popped when the DUT's result is due.
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        start;
  logic        annul;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        stall;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [1:0]  dbgState;

  logic [63:0] exp_q[$];
  int          total;
  int          bad;
  logic [31:0] curHi;
  logic [31:0] curLo;

  ex_muldiv dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .annul    (annul),
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .stall    (stall),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .dbgState (dbgState)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference arithmetic for {HI, LO}
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] sa, sb;
    logic [31:0] ma, mb, q, r;
    logic        sgn;
    model = 64'd0;
    sgn   = (o == 3'd0) || (o == 3'd2);
    if (o == 3'd0 || o == 3'd1) begin
      sa = sgn ? {{32{a[31]}}, a} : {32'd0, a};
      sb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
      model = sa * sb;
    end else if (b == 32'd0) begin
      model = {a, 32'hFFFF_FFFF};
    end else begin
      ma = (sgn && a[31]) ? -a : a;
      mb = (sgn && b[31]) ? -b : b;
      q  = ma / mb;
      r  = ma % mb;
      if (sgn && (a[31] ^ b[31])) q = -q;
      if (sgn && a[31]) r = -r;
      model = {r, q};
    end
  endfunction

  // Drive one mul/div op, count stall cycles, check result in the DONE cycle.
  // annulAt >= 1 raises annul during that cycle of the operation.
  task automatic do_muldiv(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                           input int annulAt, input string name);
    logic [63:0] e;
    int n;
    exp_q.push_back(model(o, a, b));
    @(negedge clk);
    start = 1'b1; annul = 1'b0; op = o; src_a = a; src_b = b;
    #1;
    n = 0;
    while (stall && n < 40) begin
      n++;
      @(negedge clk);
      start = 1'b0;
      annul = (n == annulAt);
      src_a = $urandom;
      src_b = $urandom;
      #1;
      if (n >= 1 && n <= 32) begin
        total++;
        if (busy !== 1'b1) begin
          bad++;
          $display("FAIL %s busy cyc%0d: got %b want 1", name, n, busy);
        end
      end
    end
    start = 1'b0;
    annul = 1'b0;
    total++;
    if (n !== 33) begin
      bad++;
      $display("FAIL %s stall_cycles: got %0d want 33", name, n);
    end
    e = exp_q.pop_front();
    total++;
    if ({hi, lo} !== e) begin
      bad++;
      $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, e[63:32], e[31:0]);
    end
    total++;
    if (dbgState !== 2'd2) begin
      bad++;
      $display("FAIL %s done_state: got %0d want 2", name, dbgState);
    end
    curHi = e[63:32];
    curLo = e[31:0];
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; annul = 1'b0; op = 3'd0; src_a = 32'd0; src_b = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({stall, busy, dbgState} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ctrl: got stall=%b busy=%b state=%0d want 0 0 0", stall, busy, dbgState);
    end
    total++;
    if ({hi, lo} !== 64'd0) begin
      bad++;
      $display("FAIL reset_hilo: got hi=%h lo=%h want 0 0", hi, lo);
    end
    curHi = 32'd0;
    curLo = 32'd0;
  endtask

  task automatic test_mul();
    do_muldiv(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, "multu_max");
    total++;
    if ({hi, lo} !== {32'hFFFF_FFFE, 32'h0000_0001}) begin
      bad++;
      $display("FAIL multu_max_const: got hi=%h lo=%h want hi=fffffffe lo=00000001", hi, lo);
    end
    do_muldiv(3'd0, 32'hFFFF_FFFD, 32'd7, -1, "mult_neg");
    total++;
    if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFEB}) begin
      bad++;
      $display("FAIL mult_neg_const: got hi=%h lo=%h want hi=ffffffff lo=ffffffeb", hi, lo);
    end
  endtask

  // Runs directly after test_mul: the first op is accepted in the cycle after DONE.
  task automatic test_back_to_back();
    do_muldiv(3'd2, 32'hFFFF_FFF9, 32'd2, -1, "div_neg");
    total++;
    if ({hi, lo} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
      bad++;
      $display("FAIL div_neg_const: got hi=%h lo=%h want hi=ffffffff lo=fffffffd", hi, lo);
    end
    do_muldiv(3'd3, 32'd100, 32'd0, -1, "divu_zero");
    do_muldiv(3'd2, 32'd100, 32'd0, -1, "div_zero");
    do_muldiv(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
    total++;
    if ({hi, lo} !== {32'h0000_0000, 32'h8000_0000}) begin
      bad++;
      $display("FAIL div_ovf_const: got hi=%h lo=%h want hi=0 lo=80000000", hi, lo);
    end
    do_muldiv(3'd2, 32'd7, 32'hFFFF_FFFE, -1, "div_pos_neg");
  endtask

  task automatic test_mt();
    @(negedge clk);
    exp_q.push_back({32'h1234_5678, curLo});
    start = 1'b1; annul = 1'b0; op = 3'd4; src_a = 32'h1234_5678; src_b = $urandom;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL mthi_stall: got %b want 0", stall);
    end
    @(negedge clk);
    exp_q.push_back({32'h1234_5678, 32'h9ABC_DEF0});
    op = 3'd5; src_a = 32'h9ABC_DEF0;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL mtlo_stall: got %b want 0", stall);
    end
    total++;
    if ({hi, lo} !== exp_q[0]) begin
      bad++;
      $display("FAIL mthi_value: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, exp_q[0][63:32], exp_q[0][31:0]);
    end
    void'(exp_q.pop_front());
    @(negedge clk);
    op = 3'd6;  // no-op with start still high: must not disturb HI/LO
    #1;
    total++;
    if ({hi, lo} !== exp_q[0] || stall !== 1'b0) begin
      bad++;
      $display("FAIL mtlo_value: got hi=%h lo=%h stall=%b want hi=%h lo=%h stall=0", hi, lo, stall, exp_q[0][63:32], exp_q[0][31:0]);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    total++;
    if ({hi, lo} !== exp_q[0]) begin
      bad++;
      $display("FAIL nop_value: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, exp_q[0][63:32], exp_q[0][31:0]);
    end
    curHi = exp_q[0][63:32];
    curLo = exp_q[0][31:0];
    void'(exp_q.pop_front());
  endtask

  task automatic test_annul();
    @(negedge clk);
    start = 1'b1; annul = 1'b1; op = 3'd3; src_a = 32'd10; src_b = 32'd3;
    #1;
    total++;
    if (stall !== 1'b0) begin
      bad++;
      $display("FAIL annul_stall: got %b want 0", stall);
    end
    @(negedge clk);
    start = 1'b0; annul = 1'b0;
    #1;
    total++;
    if ({dbgState, busy, stall} !== 4'b0000) begin
      bad++;
      $display("FAIL annul_state: got state=%0d busy=%b stall=%b want 0 0 0", dbgState, busy, stall);
    end
    total++;
    if ({hi, lo} !== {curHi, curLo}) begin
      bad++;
      $display("FAIL annul_hilo: got hi=%h lo=%h want hi=%h lo=%h", hi, lo, curHi, curLo);
    end
    do_muldiv(3'd3, 32'd10, 32'd3, 10, "divu_annul_mid");
    total++;
    if ({hi, lo} !== {32'd1, 32'd3}) begin
      bad++;
      $display("FAIL divu_annul_const: got hi=%h lo=%h want hi=1 lo=3", hi, lo);
    end
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    start = 1'b1; annul = 1'b0; op = 3'd0; src_a = 32'h0001_2345; src_b = 32'hFFFF_0001;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 15) rst = 1'b1;
    end
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_busy_before: got %b want 1", busy);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({dbgState, busy, stall} !== 4'b0000) begin
      bad++;
      $display("FAIL rst_mid_ctrl: got state=%0d busy=%b stall=%b want 0 0 0", dbgState, busy, stall);
    end
    total++;
    if ({hi, lo} !== 64'd0) begin
      bad++;
      $display("FAIL rst_mid_hilo: got hi=%h lo=%h want 0 0", hi, lo);
    end
    curHi = 32'd0;
    curLo = 32'd0;
    do_muldiv(3'd1, 32'd6, 32'd7, -1, "multu_after_rst");
    total++;
    if ({hi, lo} !== {32'd0, 32'd42}) begin
      bad++;
      $display("FAIL multu_after_rst_const: got hi=%h lo=%h want hi=0 lo=42", hi, lo);
    end
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      do_muldiv(o, a, b, -1, "random");
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mul();
    test_back_to_back();
    test_mt();
    test_annul();
    test_rst_mid();
    test_random();
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
